// File: rtl/sid_pkg.sv
// Shared definitions for the SID voice path: widths, VCA state
// encoding and a sign-extension helper used by the serial multiplier.
package sid_pkg;

    localparam int SID_WAVE_W    = 12;
    localparam int SID_ENV_W     = 8;
    localparam int SID_VCA_ACC_W = 20;
    localparam int SID_VCA_OUT_W = 16;

    typedef enum logic {
        VCA_IDLE = 1'b0,
        VCA_MUL  = 1'b1
    } vca_state_t;

    function automatic logic signed [SID_VCA_ACC_W-1:0] sid_sext_acc(
        input logic signed [SID_WAVE_W-1:0] a
    );
        return {{(SID_VCA_ACC_W-SID_WAVE_W){a[SID_WAVE_W-1]}}, a};
    endfunction

endpackage

// File: rtl/sid_serial_mul.sv
// Bit-serial shift-add multiplier: signed 12b x unsigned 8b -> signed 20b.
// Ports: clk, reset (sync, active-high); start latches a/b when idle;
// busy while multiplying; done is high in the final MUL cycle, when
// product carries the finished sum (it is the value the acc takes on
// that edge). One product per 8 clocks after the start edge.
module sid_serial_mul
    import sid_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic signed [SID_WAVE_W-1:0]    a,
    input  logic        [SID_ENV_W-1:0]     b,
    output logic                            busy,
    output logic                            done,
    output logic signed [SID_VCA_ACC_W-1:0] product
);

    vca_state_t                      state_q;
    logic                      [2:0] count_q;
    logic signed [SID_VCA_ACC_W-1:0] acc_q;
    logic signed [SID_WAVE_W-1:0]    a_q;
    logic        [SID_ENV_W-1:0]     b_q;
    logic signed [SID_VCA_ACC_W-1:0] term;

    // Partial product for the current multiplier bit.
    always_comb begin
        term = '0;
        if (b_q[count_q]) begin
            term = sid_sext_acc(a_q) <<< count_q;
        end
    end

    assign product = acc_q + term;
    assign busy    = (state_q == VCA_MUL);
    assign done    = busy && (count_q == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= VCA_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            unique case (state_q)
                VCA_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= '0;
                        count_q <= '0;
                        state_q <= VCA_MUL;
                    end
                end
                VCA_MUL: begin
                    acc_q   <= product;
                    count_q <= count_q + 3'd1;
                    if (count_q == 3'd7) begin
                        state_q <= VCA_IDLE;
                    end
                end
                default: state_q <= VCA_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sid_vca.sv
// SID voice amplitude stage: scales the 12-bit waveform by the envelope.
// Ports: clk, reset (sync, active-high), sample_en/wave/env/mute in;
// out (signed 16b, held), out_valid pulse, busy, dropped pulse out.
// Macro SID_VCA_DC_OFFSET_EN adds saturating DC_OFFSET to each result.
module sid_vca
    import sid_pkg::*;
#(
    parameter logic signed [SID_VCA_OUT_W-1:0] DC_OFFSET = 16'sd0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sample_en,
    input  logic        [SID_WAVE_W-1:0]    wave,
    input  logic        [SID_ENV_W-1:0]     env,
    input  logic                            mute,
    output logic signed [SID_VCA_OUT_W-1:0] out,
    output logic                            out_valid,
    output logic                            busy,
    output logic                            dropped
);

    logic signed [SID_WAVE_W-1:0]    ws;
    logic        [SID_ENV_W-1:0]     em;
    logic                            mul_start;
    logic                            mul_busy;
    logic                            mul_done;
    logic signed [SID_VCA_ACC_W-1:0] product;
    logic signed [SID_VCA_OUT_W-1:0] r;
    logic signed [SID_VCA_OUT_W-1:0] result;
    logic                            unused_bits;

    // Offset-binary to two's complement: midscale 12'h800 maps to 0.
    assign ws        = {~wave[SID_WAVE_W-1], wave[SID_WAVE_W-2:0]};
    assign em        = mute ? '0 : env;
    assign mul_start = sample_en & ~mul_busy;
    assign busy      = mul_busy;

    // Arithmetic >>4, flooring toward -inf.
    assign r = product[SID_VCA_ACC_W-1:SID_VCA_ACC_W-SID_VCA_OUT_W];

    sid_serial_mul u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (ws),
        .b       (em),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

`ifdef SID_VCA_DC_OFFSET_EN
    logic signed [SID_VCA_OUT_W:0] dc_sum;

    assign dc_sum = {r[SID_VCA_OUT_W-1], r}
                  + {DC_OFFSET[SID_VCA_OUT_W-1], DC_OFFSET};

    // Overflow when the two top bits of the 17-bit sum disagree.
    always_comb begin
        result = dc_sum[SID_VCA_OUT_W-1:0];
        if (dc_sum[SID_VCA_OUT_W] != dc_sum[SID_VCA_OUT_W-1]) begin
            result = dc_sum[SID_VCA_OUT_W] ? 16'sh8000 : 16'sh7FFF;
        end
    end

    assign unused_bits = ^product[SID_VCA_ACC_W-SID_VCA_OUT_W-1:0];
`else
    assign result      = r;
    assign unused_bits = ^product[SID_VCA_ACC_W-SID_VCA_OUT_W-1:0]
                       ^ (^DC_OFFSET);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            out_valid <= mul_done;
            dropped   <= sample_en & mul_busy;
            if (mul_done) begin
                out <= result;
            end
        end
    end

endmodule

// File: tb/tb_sid_vca.sv
// Self-checking bench for sid_vca: directed cases plus randomized
// samples against an arithmetic reference model.
module tb_sid_vca;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_en;
    logic        [11:0] wave;
    logic        [7:0]  env;
    logic               mute;
    logic signed [15:0] out;
    logic               out_valid;
    logic               busy;
    logic               dropped;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic signed [15:0] TB_DC = 16'sh1000;

    always #5 clk = ~clk;

    sid_vca #(.DC_OFFSET(TB_DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .wave      (wave),
        .env       (env),
        .mute      (mute),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .dropped   (dropped)
    );

    // Reference: (wave - 2048) * level, floor-divided by 16.
    function automatic logic [15:0] model(input logic [11:0] w,
                                          input logic [7:0] e,
                                          input logic m);
        int ws, em, r;
        ws = int'(w) - 2048;
        em = m ? 0 : int'(e);
        r  = (ws * em) >>> 4;
`ifdef SID_VCA_DC_OFFSET_EN
        r = r + int'(TB_DC);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    // Called just after a negedge; returns result and clocks from capture.
    task automatic do_sample(input logic [11:0] w, input logic [7:0] e,
                             input logic m, output logic [15:0] o,
                             output int lat);
        sample_en = 1'b1;
        wave = w;
        env  = e;
        mute = m;
        @(negedge clk);
        sample_en = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            wave = 12'($urandom);
            env  = 8'($urandom);
            mute = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        o = out;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        sample_en = 1'b1;
        wave      = 12'hFFF;
        env       = 8'hFF;
        mute      = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out !== 16'sh0000) begin
            n_fail++;
            $display("FAIL reset_out got %h want 0000", out);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        n_cmp++;
        if (dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dropped got %b want 0", dropped);
        end
        sample_en = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [11:0] tw [6] = '{12'hFFF, 12'h000, 12'h800,
                                12'hC00, 12'hC00, 12'hFFF};
        logic [7:0]  te [6] = '{8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h01};
        logic        tm [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef SID_VCA_DC_OFFSET_EN
        logic [15:0] tx [6] = '{16'h7FFF, 16'h9080, 16'h1000,
                                16'h3000, 16'h1000, 16'h107F};
`else
        logic [15:0] tx [6] = '{16'h7F70, 16'h8080, 16'h0000,
                                16'h2000, 16'h0000, 16'h007F};
`endif
        logic [15:0] o;
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_sample(tw[i], te[i], tm[i], o, lat);
            n_cmp++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL dir_latency[%0d] got %0d want 8", i, lat);
            end
            n_cmp++;
            if (o !== tx[i]) begin
                n_fail++;
                $display("FAIL dir_out[%0d] got %h want %h", i, o, tx[i]);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL dir_busy[%0d] got %b want 0", i, busy);
            end
        end
`ifdef SID_VCA_DC_OFFSET_EN
        repeat (2) @(negedge clk);
        do_sample(12'h800, 8'h00, 1'b0, o, lat);
        n_cmp++;
        if (o !== 16'h1000) begin
            n_fail++;
            $display("FAIL dc_zero got %h want 1000", o);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_drop();
        int lat;
        int pulses;
        sample_en = 1'b1;
        wave = 12'hFFF;
        env  = 8'hFF;
        mute = 1'b0;
        @(negedge clk);
        sample_en = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_busy got %b want 1", busy);
        end
        repeat (2) @(negedge clk);
        sample_en = 1'b1;
        wave = 12'h000;
        env  = 8'h10;
        @(negedge clk);
        sample_en = 1'b0;
        n_cmp++;
        if (dropped !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_pulse got %b want 1", dropped);
        end
        lat = 3;
        pulses = 0;
        @(negedge clk);
        lat++;
        n_cmp++;
        if (dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_width got %b want 0", dropped);
        end
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL drop_latency got %0d want 8", lat);
        end
        n_cmp++;
        if (out !== model(12'hFFF, 8'hFF, 1'b0)) begin
            n_fail++;
            $display("FAIL drop_out got %h want %h", out,
                     model(12'hFFF, 8'hFF, 1'b0));
        end
        repeat (12) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL drop_extra_valid got %0d want 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] o;
        int lat;
        int pulses;
        sample_en = 1'b1;
        wave = 12'h000;
        env  = 8'hFF;
        mute = 1'b0;
        @(negedge clk);
        sample_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_busy got %b want 0", busy);
        end
        n_cmp++;
        if (out !== 16'sh0000) begin
            n_fail++;
            $display("FAIL rmid_out got %h want 0000", out);
        end
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL rmid_valid got %0d want 0", pulses);
        end
        do_sample(12'hFFF, 8'h01, 1'b0, o, lat);
        n_cmp++;
        if (o !== model(12'hFFF, 8'h01, 1'b0) || lat !== 8) begin
            n_fail++;
            $display("FAIL rmid_next got %h lat %0d want %h lat 8",
                     o, lat, model(12'hFFF, 8'h01, 1'b0));
        end
    endtask

    // Samples issued in the very cycle the previous out_valid is high.
    task automatic test_random_back_to_back();
        logic [11:0] w;
        logic [7:0]  e;
        logic        m;
        logic [15:0] o;
        int lat;
        for (int i = 0; i < 40; i++) begin
            w = 12'($urandom);
            e = 8'($urandom);
            m = ($urandom_range(3) == 0);
            if (i % 8 == 0) e = 8'hFF;
            if (i % 8 == 1) w = 12'h000;
            do_sample(w, e, m, o, lat);
            n_cmp++;
            if (o !== model(w, e, m) || lat !== 8) begin
                n_fail++;
                $display("FAIL rand[%0d] w=%h e=%h m=%b got %h lat %0d want %h lat 8",
                         i, w, e, m, o, lat, model(w, e, m));
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        sample_en = 1'b0;
        wave      = '0;
        env       = '0;
        mute      = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_drop();
        test_reset_mid();
        test_random_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
